// File: rtl/i2s_transmitter_pkg.sv
// Shared I2S constants: word-select polarity and the minimum slot width.
package i2s_transmitter_pkg;

    localparam logic LRCLK_LEFT      = 1'b0;
    localparam logic LRCLK_RIGHT     = 1'b1;
    localparam int   MIN_AUDIO_WIDTH = 2;

    function automatic bit audio_width_ok(input int width);
        return width >= MIN_AUDIO_WIDTH;
    endfunction

endpackage

// File: rtl/i2s_clock_gen.sv
// Bit-clock divider: sclk toggles every clk_div cycles; fall marks the
// cycle whose clock edge drives sclk from 1 to 0.
module i2s_clock_gen #(
    parameter int clk_div = 4
) (
    input  logic clk,
    input  logic reset,
    output logic sclk,
    output logic fall
);

    localparam int CNT_W = (clk_div > 1) ? $clog2(clk_div) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(clk_div - 1);

    logic [CNT_W-1:0] div_cnt;
    logic             wrap;

    assign wrap = (div_cnt == CNT_LAST);
    assign fall = wrap && sclk;

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
            sclk    <= 1'b0;
        end else if (wrap) begin
            div_cnt <= '0;
            sclk    <= ~sclk;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/i2s_transmitter.sv
// I2S master transmitter: two-entry per-channel holding buffer feeding a
// slot shift register that changes data and word select on sclk falling edges.
module i2s_transmitter
    import i2s_transmitter_pkg::*;
#(
    parameter int audio_width = 16,
    parameter int clk_div     = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_valid,
    output logic                          i_ready,
    input  logic                          i_is_left,
    input  logic signed [audio_width-1:0] i_audio,
    output logic                          o_sclk,
    output logic                          o_lrclk,
    output logic                          o_sdata,
    output logic                          o_underrun
);

    if (!audio_width_ok(audio_width)) begin : g_width_check
        $error("i2s_transmitter: audio_width must be at least %0d", MIN_AUDIO_WIDTH);
    end

    localparam int P_W = $clog2(audio_width);
    localparam logic [P_W-1:0] P_LAST = P_W'(audio_width - 1);

    logic                          fall;
    logic [P_W-1:0]                p;
    logic [audio_width-1:0]        shift;
    logic signed [audio_width-1:0] hold_l;
    logic signed [audio_width-1:0] hold_r;
    logic                          hold_l_v;
    logic                          hold_r_v;
    logic                          accept_l;
    logic                          accept_r;
    logic                          slot_start;
    logic                          next_lr;
    logic                          load_l;
    logic                          load_r;
    logic                          load_v;
    logic [audio_width-1:0]        load_word;

    i2s_clock_gen #(
        .clk_div(clk_div)
    ) u_clock_gen (
        .clk  (clk),
        .reset(reset),
        .sclk (o_sclk),
        .fall (fall)
    );

    assign i_ready  = !reset && (i_is_left ? !hold_l_v : !hold_r_v);
    assign accept_l = i_valid && i_ready && i_is_left;
    assign accept_r = i_valid && i_ready && !i_is_left;

    assign slot_start = fall && (p == '0);
    assign next_lr    = ~o_lrclk;
    assign load_l     = slot_start && (next_lr == LRCLK_LEFT);
    assign load_r     = slot_start && (next_lr == LRCLK_RIGHT);
    assign load_v     = load_l ? hold_l_v : hold_r_v;
    // An empty register sends silence; a same-cycle accept is never bypassed.
    assign load_word  = !load_v ? '0 : (load_l ? hold_l : hold_r);

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_l_v <= 1'b0;
            hold_r_v <= 1'b0;
        end else begin
            if (accept_l)    hold_l_v <= 1'b1;
            else if (load_l) hold_l_v <= 1'b0;
            if (accept_r)    hold_r_v <= 1'b1;
            else if (load_r) hold_r_v <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (accept_l) hold_l <= i_audio;
        if (accept_r) hold_r <= i_audio;
    end

    // Slot start emits the previous word's LSB: the standard one-bit I2S delay.
    always_ff @(posedge clk) begin
        if (reset) begin
            p          <= '0;
            shift      <= '0;
            o_lrclk    <= LRCLK_RIGHT;
            o_sdata    <= 1'b0;
            o_underrun <= 1'b0;
        end else begin
            o_underrun <= slot_start && !load_v;
            if (fall) begin
                o_sdata <= shift[audio_width-1];
                p       <= (p == P_LAST) ? '0 : p + 1'b1;
                if (slot_start) begin
                    o_lrclk <= next_lr;
                    shift   <= load_word;
                end else begin
                    shift <= shift << 1;
                end
            end
        end
    end

endmodule
